// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory requester.
// State encoding, default timeout and the read value returned on timeout.
package data_mem_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned TIMEOUT_DEFAULT = 15;
   localparam logic [31:0] ERR_RDATA       = 32'h0;

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/req_timer.sv
// Wait-cycle counter for an outstanding memory request.
// Saturates at TIMEOUT; expired_o flags the cycle in which the count reaches TIMEOUT.
module req_timer
   import data_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned TO_W    = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [TO_W-1:0] Limit   = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] LastCnt = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q < Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // The increment taking place this cycle is the one that reaches TIMEOUT.
   assign expired_o = en_i && (cnt_q >= LastCnt);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/data_mem_requester.sv
// MEM-stage data memory initiator: turns level read/write controls into a registered
// req/ack transaction, stalls the pipeline meanwhile, flags misalignment and timeouts.
module data_mem_requester
   import data_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned TO_W    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] writedata_i,
   input  logic        memread_i,
   input  logic        memwrite_i,
   output logic [31:0] readdata_o,
   output logic        stall_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] readdata_q, readdata_d;
   logic        err_q, err_d;

   logic        req_present;
   logic        timer_clear;
   logic        timer_en;
   logic        timer_expired;

   assign req_present = memread_i | memwrite_i;
   assign timer_en    = (state_q == StWait);

   req_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_req_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (timer_clear),
      .en_i      (timer_en),
      .expired_o (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      readdata_d  = readdata_q;
      err_d       = 1'b0;
      timer_clear = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_present) begin
               if (is_word_aligned(addr_i[1:0])) begin
                  mem_addr_d  = {addr_i[31:2], 2'b00};
                  mem_wdata_d = writedata_i;
                  mem_we_d    = memwrite_i;
                  mem_req_d   = 1'b1;
                  timer_clear = 1'b1;
                  state_d     = StWait;
               end else begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StWait: begin
            // An ack in the expiry cycle still completes the access cleanly.
            if (mem_ack_i) begin
               if (!mem_we_q) begin
                  readdata_d = mem_rdata_i;
               end
               mem_req_d = 1'b0;
               state_d   = StDone;
            end else if (timer_expired) begin
               if (!mem_we_q) begin
                  readdata_d = ERR_RDATA;
               end
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               state_d   = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         readdata_q  <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         readdata_q  <= readdata_d;
         err_q       <= err_d;
      end
   end

   assign stall_o     = ((state_q == StIdle) && req_present) || (state_q == StWait);
   assign readdata_o  = readdata_q;
   assign err_o       = err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Directed bench for data_mem_requester: a transaction-level model expands each access
// into per-cycle expected outputs, checked every cycle, plus literal end-of-access checks.
module tb_data_mem_requester;

   localparam int unsigned TO = 4;
   localparam logic [31:0] Junk = 32'hDEAD_BEEF;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] addr_i = '0;
   logic [31:0] writedata_i = '0;
   logic        memread_i = 1'b0;
   logic        memwrite_i = 1'b0;
   logic [31:0] readdata_o;
   logic        stall_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   data_mem_requester #(
      .TIMEOUT (TO),
      .TO_W    (8)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .addr_i      (addr_i),
      .writedata_i (writedata_i),
      .memread_i   (memread_i),
      .memwrite_i  (memwrite_i),
      .readdata_o  (readdata_o),
      .stall_o     (stall_o),
      .err_o       (err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic        stall;
      logic        req;
      logic        we;
      logic        err;
      logic        chk_bus;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
   } exp_t;

   exp_t        exp_q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          stall_n = 0;
   int          req_n = 0;
   int          err_n = 0;
   int          cyc_n = 0;
   logic [31:0] rd_model = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc_n, act, req);
      end
   endtask

   function automatic exp_t mk(input logic stall, input logic req, input logic we,
                               input logic err, input logic chk_bus, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rd);
      exp_t e;
      e.stall = stall; e.req = req; e.we = we; e.err = err; e.chk_bus = chk_bus;
      e.addr = addr; e.wdata = wdata; e.rd = rd;
      return e;
   endfunction

   // Per-cycle comparison against the model's expectations.
   always @(negedge clk_i) begin
      exp_t e;
      cyc_n++;
      if (!rst_i) begin
         stall_n += int'(stall_o);
         req_n   += int'(mem_req_o);
         err_n   += int'(err_o);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("stall", {31'b0, stall_o}, {31'b0, e.stall});
         chk("mem_req", {31'b0, mem_req_o}, {31'b0, e.req});
         chk("err", {31'b0, err_o}, {31'b0, e.err});
         chk("readdata", readdata_o, e.rd);
         if (e.chk_bus) begin
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, e.we});
            chk("mem_addr", mem_addr_o, e.addr);
            chk("mem_wdata", mem_wdata_o, e.wdata);
         end
      end
   end

   task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic ack, input logic [31:0] rdat,
                      input exp_t e);
      @(posedge clk_i);
      #1;
      memread_i   = rd;
      memwrite_i  = wr;
      addr_i      = a;
      writedata_i = wd;
      mem_ack_i   = ack;
      mem_rdata_i = rdat;
      exp_q.push_back(e);
   endtask

   // One access as seen by the pipeline; ack_dly < 0 means the memory never answers.
   task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input int ack_dly, input logic [31:0] rdat);
      logic is_wr;
      logic acked;
      int   nwait;
      is_wr   = wr;
      acked   = (ack_dly >= 0) && (ack_dly < int'(TO));
      nwait   = acked ? ack_dly + 1 : int'(TO);
      stall_n = 0;
      req_n   = 0;
      err_n   = 0;
      cyc(rd, wr, a, wd, 1'b0, Junk, mk(1, 0, 0, 0, 0, 0, 0, rd_model));
      if (a[1:0] != 2'b00) begin
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, Junk, mk(0, 0, 0, 1, 0, 0, 0, rd_model));
      end else begin
         for (int j = 0; j < nwait; j++) begin
            logic ack;
            ack = acked && (j == ack_dly);
            cyc(rd, wr, a, wd, ack, ack ? rdat : Junk,
                mk(1, 1, is_wr, 0, 1, a, wd, rd_model));
         end
         if (!is_wr) rd_model = acked ? rdat : 32'h0;
         cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, Junk, mk(0, 0, 0, !acked, 0, 0, 0, rd_model));
      end
      @(negedge clk_i);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
      chk("rst_err", {31'b0, err_o}, 32'h0);
      chk("rst_addr", mem_addr_o, 32'h0);
      chk("rst_wdata", mem_wdata_o, 32'h0);
      chk("rst_readdata", readdata_o, 32'h0);
      chk("rst_stall_idle", {31'b0, stall_o}, 32'h0);
      memread_i = 1'b1;
      #1;
      chk("rst_stall_req", {31'b0, stall_o}, 32'h1);
      memread_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;

      // Idle cycle: nothing happens.
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, Junk, mk(0, 0, 0, 0, 0, 0, 0, rd_model));

      txn(1'b1, 1'b0, 32'h8, 32'h0, 0, 32'h1234_5678);
      chk("rd0_stall_cycles", stall_n, 2);
      chk("rd0_req_cycles", req_n, 1);
      chk("rd0_err_cycles", err_n, 0);
      chk("rd0_readdata", readdata_o, 32'h1234_5678);

      txn(1'b0, 1'b1, 32'h1C, 32'hCAFE_F00D, 3, 32'h0);
      chk("wr3_stall_cycles", stall_n, 5);
      chk("wr3_req_cycles", req_n, 4);
      chk("wr3_readdata_kept", readdata_o, 32'h1234_5678);

      txn(1'b1, 1'b0, 32'h6, 32'h0, 0, 32'h0);
      chk("mis_stall_cycles", stall_n, 1);
      chk("mis_req_cycles", req_n, 0);
      chk("mis_err_cycles", err_n, 1);
      chk("mis_readdata_kept", readdata_o, 32'h1234_5678);

      txn(1'b1, 1'b0, 32'h20, 32'h0, -1, 32'h0);
      chk("to_req_cycles", req_n, 4);
      chk("to_stall_cycles", stall_n, 5);
      chk("to_err_cycles", err_n, 1);
      chk("to_readdata", readdata_o, 32'h0);

      txn(1'b1, 1'b0, 32'h24, 32'h0, 1, 32'h0BAD_CAFE);
      chk("rd1_readdata", readdata_o, 32'h0BAD_CAFE);

      txn(1'b1, 1'b1, 32'h28, 32'h5555_AAAA, 0, 32'h0);
      chk("both_readdata_kept", readdata_o, 32'h0BAD_CAFE);

      txn(1'b1, 1'b0, 32'h2C, 32'h0, int'(TO) - 1, 32'h600D_D00D);
      chk("ack_at_to_err_cycles", err_n, 0);
      chk("ack_at_to_readdata", readdata_o, 32'h600D_D00D);

      txn(1'b0, 1'b1, 32'h33, 32'h1111_2222, 0, 32'h0);
      chk("miswr_err_cycles", err_n, 1);
      chk("miswr_req_cycles", req_n, 0);

      // Reset two cycles into WAIT abandons the access.
      cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, Junk, mk(1, 0, 0, 0, 0, 0, 0, rd_model));
      repeat (2) cyc(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, Junk,
                     mk(1, 1, 0, 0, 1, 32'h40, 32'h0, rd_model));
      @(negedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      chk("midrst_req_drop", {31'b0, mem_req_o}, 32'h0);
      chk("midrst_stall_idle_req", {31'b0, stall_o}, 32'h1);
      memread_i = 1'b0;
      #1;
      chk("midrst_stall", {31'b0, stall_o}, 32'h0);
      chk("midrst_readdata", readdata_o, 32'h0);
      rd_model = 32'h0;
      @(negedge clk_i);
      #2;
      rst_i = 1'b0;

      txn(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'hA5A5_0001);
      chk("postrst_stall_cycles", stall_n, 3);
      chk("postrst_err_cycles", err_n, 0);
      chk("postrst_readdata", readdata_o, 32'hA5A5_0001);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
